state_dump_unit: RTL and testbench

//  Debug responder inside Pipe_CPU that streams architectural state (register file + data memory) out of
//  the core on a trigger. Trigger is a programmed cycle number or an explicit request. Records leave over
//  a valid/ready port to a host or trace sink. Replaces hierarchical peeking at fixed cycles in simulation.

---
 rtl/state_dump_unit.sv | 162 ++++++++++++++++
 tb/tb_state_dump_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/state_dump_unit.sv
// state_dump_unit: streams a header, the register file, data memory and a trailer over a valid/ready port.
// Optional macro DUMP_CHECKSUM_EN: trailer carries the XOR of all RF/DM payloads instead of the record count.
module state_dump_unit #(
   parameter int DATA_W = 32,
   parameter int RF_N   = 16,
   parameter int DM_N   = 16,
   parameter int CYC_W  = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    dump_req_i,
   input  logic                    trig_en_i,
   input  logic [CYC_W-1:0]        trig_cycle_i,
   output logic [$clog2(RF_N)-1:0] rf_addr_o,
   input  logic [DATA_W-1:0]       rf_data_i,
   output logic [$clog2(DM_N)-1:0] dm_addr_o,
   input  logic [DATA_W-1:0]       dm_data_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [1:0]              out_tag_o,
   output logic [7:0]              out_idx_o,
   output logic [DATA_W-1:0]       out_data_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic [CYC_W-1:0]        cycle_o
);
   localparam int RF_AW = $clog2(RF_N);
   localparam int DM_AW = $clog2(DM_N);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RF   = 3'd1;
   localparam logic [2:0] S_DM   = 3'd2;
   localparam logic [2:0] S_TRL  = 3'd3;
   localparam logic [2:0] S_FIN  = 3'd4;

   localparam logic [1:0] TAG_HDR = 2'd0;
   localparam logic [1:0] TAG_RF  = 2'd1;
   localparam logic [1:0] TAG_DM  = 2'd2;
   localparam logic [1:0] TAG_TRL = 2'd3;

   localparam logic [7:0] RF_LAST = 8'(RF_N - 1);
   localparam logic [7:0] DM_LAST = 8'(DM_N - 1);

   logic [2:0]        st_p0;
   logic [7:0]        idx_p0;
   logic [CYC_W-1:0]  cyc_p0;
   logic              vld_p1;
   logic [1:0]        tag_p1;
   logic [7:0]        idx_p1;
   logic [DATA_W-1:0] data_p1;
   logic              done_p1;
   logic              start;
   logic              load;
   logic [DATA_W-1:0] trl_data;

   // st_p0/idx_p0 name the record to be loaded next; the output register holds the one on offer.
   assign start = (st_p0 == S_IDLE) &
                  (dump_req_i | (trig_en_i & (cyc_p0 == trig_cycle_i)));
   assign load  = ~vld_p1 | out_ready_i;

`ifdef DUMP_CHECKSUM_EN
   logic [DATA_W-1:0] csum_p1;

   always_ff @(posedge clk_i) begin
      if (rst_i || start) begin
         csum_p1 <= '0;
      end else if (load && (st_p0 == S_RF)) begin
         csum_p1 <= csum_p1 ^ rf_data_i;
      end else if (load && (st_p0 == S_DM)) begin
         csum_p1 <= csum_p1 ^ dm_data_i;
      end
   end

   assign trl_data = csum_p1;
`else
   assign trl_data = DATA_W'(RF_N + DM_N);
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         st_p0   <= S_IDLE;
         idx_p0  <= '0;
         cyc_p0  <= '0;
         vld_p1  <= 1'b0;
         tag_p1  <= '0;
         idx_p1  <= '0;
         data_p1 <= '0;
         done_p1 <= 1'b0;
      end else begin
         cyc_p0  <= cyc_p0 + CYC_W'(1);
         done_p1 <= 1'b0;
         case (st_p0)
            S_IDLE: begin
               if (start) begin
                  vld_p1  <= 1'b1;
                  tag_p1  <= TAG_HDR;
                  idx_p1  <= '0;
                  data_p1 <= DATA_W'(cyc_p0);
                  idx_p0  <= '0;
                  st_p0   <= S_RF;
               end
            end
            S_RF: begin
               if (load) begin
                  vld_p1  <= 1'b1;
                  tag_p1  <= TAG_RF;
                  idx_p1  <= idx_p0;
                  data_p1 <= rf_data_i;
                  if (idx_p0 == RF_LAST) begin
                     idx_p0 <= '0;
                     st_p0  <= S_DM;
                  end else begin
                     idx_p0 <= idx_p0 + 8'd1;
                  end
               end
            end
            S_DM: begin
               if (load) begin
                  vld_p1  <= 1'b1;
                  tag_p1  <= TAG_DM;
                  idx_p1  <= idx_p0;
                  data_p1 <= dm_data_i;
                  if (idx_p0 == DM_LAST) begin
                     idx_p0 <= '0;
                     st_p0  <= S_TRL;
                  end else begin
                     idx_p0 <= idx_p0 + 8'd1;
                  end
               end
            end
            S_TRL: begin
               if (load) begin
                  vld_p1  <= 1'b1;
                  tag_p1  <= TAG_TRL;
                  idx_p1  <= '0;
                  data_p1 <= trl_data;
                  st_p0   <= S_FIN;
               end
            end
            S_FIN: begin
               if (out_ready_i) begin
                  vld_p1  <= 1'b0;
                  done_p1 <= 1'b1;
                  st_p0   <= S_IDLE;
               end
            end
            default: st_p0 <= S_IDLE;
         endcase
      end
   end

   assign rf_addr_o   = (st_p0 == S_RF) ? idx_p0[RF_AW-1:0] : '0;
   assign dm_addr_o   = (st_p0 == S_DM) ? idx_p0[DM_AW-1:0] : '0;
   assign out_valid_o = vld_p1;
   assign out_tag_o   = tag_p1;
   assign out_idx_o   = idx_p1;
   assign out_data_o  = data_p1;
   assign busy_o      = (st_p0 != S_IDLE);
   assign done_o      = done_p1;
   assign cycle_o     = cyc_p0;

endmodule

// File: tb/tb_state_dump_unit.sv
// Self-checking bench for state_dump_unit: record-list reference model built at each dump start.
// Trailer expectation follows DUMP_CHECKSUM_EN the same way the design does.
module tb_state_dump_unit;
   localparam int DATA_W = 32;
   localparam int RF_N   = 16;
   localparam int DM_N   = 16;
   localparam int CYC_W  = 16;

   typedef struct {
      logic [1:0]  tag;
      logic [7:0]  idx;
      logic [31:0] data;
   } rec_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              dump_req;
   logic              trig_en;
   logic [CYC_W-1:0]  trig_cycle;
   logic [3:0]        rf_addr;
   logic [DATA_W-1:0] rf_data;
   logic [3:0]        dm_addr;
   logic [DATA_W-1:0] dm_data;
   logic              out_valid;
   logic              out_ready;
   logic [1:0]        out_tag;
   logic [7:0]        out_idx;
   logic [DATA_W-1:0] out_data;
   logic              busy;
   logic              done;
   logic [CYC_W-1:0]  cycle;

   logic [31:0] rf_mem [0:RF_N-1];
   logic [31:0] dm_mem [0:DM_N-1];

   rec_t        exp_q[$];
   logic [15:0] mcyc = '0;
   logic        done_exp = 1'b0;
   logic        take = 1'b0;
   logic        chk_on = 1'b0;
   int          rdy_mode = 0;
   int          rdy_ph = 0;
   logic [3:0]  rdy_pat = 4'b1001;

   int          n_chk = 0;
   int          n_err = 0;
   int          hdr_cnt = 0;
   int          rec_cnt = 0;
   logic [31:0] last_hdr = '0;
   logic [31:0] last_trl = '0;

   always #5 clk = ~clk;

   assign rf_data = rf_mem[rf_addr];
   assign dm_data = dm_mem[dm_addr];

   state_dump_unit #(.DATA_W(DATA_W), .RF_N(RF_N), .DM_N(DM_N), .CYC_W(CYC_W)) dut (
      .clk_i(clk), .rst_i(rst), .dump_req_i(dump_req), .trig_en_i(trig_en),
      .trig_cycle_i(trig_cycle), .rf_addr_o(rf_addr), .rf_data_i(rf_data),
      .dm_addr_o(dm_addr), .dm_data_i(dm_data), .out_valid_o(out_valid),
      .out_ready_i(out_ready), .out_tag_o(out_tag), .out_idx_o(out_idx),
      .out_data_o(out_data), .busy_o(busy), .done_o(done), .cycle_o(cycle)
   );

   function automatic rec_t mk(input logic [1:0] t, input logic [7:0] i, input logic [31:0] d);
      rec_t r;
      r.tag  = t;
      r.idx  = i;
      r.data = d;
      return r;
   endfunction

   // Reference model: a dump is the whole ordered record list, built when a start is accepted.
   always @(posedge clk) begin
      logic [31:0] csum;
      chk_on = 1'b1;
      if (rst) begin
         mcyc = '0;
         exp_q.delete();
         done_exp = 1'b0;
      end else begin
         done_exp = 1'b0;
         if (exp_q.size() != 0) begin
            if (take) begin
               if (exp_q[0].tag == 2'd3) done_exp = 1'b1;
               void'(exp_q.pop_front());
            end
         end else if (dump_req || (trig_en && (mcyc == trig_cycle))) begin
            csum = '0;
            exp_q.push_back(mk(2'd0, 8'd0, 32'(mcyc)));
            for (int i = 0; i < RF_N; i++) begin
               exp_q.push_back(mk(2'd1, 8'(i), rf_mem[i]));
               csum = csum ^ rf_mem[i];
            end
            for (int i = 0; i < DM_N; i++) begin
               exp_q.push_back(mk(2'd2, 8'(i), dm_mem[i]));
               csum = csum ^ dm_mem[i];
            end
`ifdef DUMP_CHECKSUM_EN
            exp_q.push_back(mk(2'd3, 8'd0, csum));
`else
            exp_q.push_back(mk(2'd3, 8'd0, 32'(RF_N + DM_N)));
`endif
         end
         mcyc = mcyc + 16'd1;
      end
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic mon();
      logic busy_e;
      take = 1'b0;
      if (!chk_on) return;
      busy_e = (exp_q.size() != 0);
      check_val("cycle", 64'(cycle), 64'(mcyc));
      check_val("busy", 64'(busy), 64'(busy_e));
      check_val("valid", 64'(out_valid), 64'(busy_e));
      check_val("done", 64'(done), 64'(done_exp));
      if (out_valid && busy_e) begin
         check_val("tag", 64'(out_tag), 64'(exp_q[0].tag));
         check_val("idx", 64'(out_idx), 64'(exp_q[0].idx));
         check_val("data", 64'(out_data), 64'(exp_q[0].data));
         take = out_ready;
      end
      if (out_valid && out_ready) begin
         if (out_tag == 2'd0) begin
            hdr_cnt++;
            last_hdr = out_data;
            rec_cnt = 0;
         end
         if (out_tag == 2'd3) last_trl = out_data;
         rec_cnt++;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      mon();
      @(posedge clk);
      #1;
      case (rdy_mode)
         1:       out_ready = 1'($urandom_range(0, 1));
         2: begin out_ready = rdy_pat[rdy_ph[1:0]]; rdy_ph++; end
         default: out_ready = 1'b1;
      endcase
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((exp_q.size() != 0 || done_exp) && n < 2000) begin
         tick();
         n++;
      end
      check_val({tag, "_timeout"}, 64'(n < 2000), 64'(1));
   endtask

   task automatic fill_rand();
      for (int i = 0; i < RF_N; i++) rf_mem[i] = $urandom;
      for (int i = 0; i < DM_N; i++) dm_mem[i] = $urandom;
   endtask

   task automatic pulse_req();
      dump_req = 1'b1;
      tick();
      dump_req = 1'b0;
   endtask

   initial begin
      int          h0;
      int          n;
      logic [31:0] expv;
      logic [15:0] tc;
      rst = 1'b1; dump_req = 1'b0; trig_en = 1'b0; trig_cycle = '0; out_ready = 1'b1;
      fill_rand();
      repeat (3) tick();
      check_val("rst_valid", 64'(out_valid), 64'(0));
      check_val("rst_busy", 64'(busy), 64'(0));
      check_val("rst_cycle", 64'(cycle), 64'(0));
      check_val("rst_tag", 64'(out_tag), 64'(0));
      rst = 1'b0;

      // Request pulse sampled with cycle_o == 5.
      n = 0;
      while (mcyc != 16'd5 && n < 50) begin tick(); n++; end
      pulse_req();
      wait_idle("t1");
      check_val("t1_hdr_cnt", 64'(hdr_cnt), 64'(1));
      check_val("t1_hdr", 64'(last_hdr), 64'(5));
      check_val("t1_records", 64'(rec_cnt), 64'(34));

      // Cycle-match trigger at 12, fires once.
      rst = 1'b1; tick(); rst = 1'b0;
      trig_en = 1'b1; trig_cycle = 16'd12; h0 = hdr_cnt;
      repeat (100) tick();
      check_val("t2_dumps", 64'(hdr_cnt - h0), 64'(1));
      check_val("t2_hdr", 64'(last_hdr), 64'(12));
      trig_en = 1'b0;

      // Ready toggling 1,0,0,1.
      fill_rand(); rdy_mode = 2; rdy_ph = 0; h0 = hdr_cnt;
      pulse_req();
      wait_idle("t3");
      check_val("t3_dumps", 64'(hdr_cnt - h0), 64'(1));
      check_val("t3_records", 64'(rec_cnt), 64'(34));
      rdy_mode = 0;

      // Known memory image, trailer payload.
      for (int i = 0; i < RF_N; i++) rf_mem[i] = 32'(i * 3);
      for (int i = 0; i < DM_N; i++) dm_mem[i] = 32'(100 + i);
      pulse_req();
      wait_idle("t4");
`ifdef DUMP_CHECKSUM_EN
      expv = '0;
      for (int i = 0; i < 16; i++) expv = expv ^ 32'(i * 3) ^ 32'(100 + i);
`else
      expv = 32'd32;
`endif
      check_val("t4_trailer", 64'(last_trl), 64'(expv));

      // Request and cycle match together, then requests while busy.
      fill_rand(); h0 = hdr_cnt;
      tc = mcyc + 16'd4; trig_cycle = tc; trig_en = 1'b1;
      n = 0;
      while (mcyc != tc && n < 20) begin tick(); n++; end
      pulse_req();
      repeat (3) tick();
      dump_req = 1'b1; repeat (2) tick(); dump_req = 1'b0;
      trig_en = 1'b0;
      wait_idle("t5");
      check_val("t5_dumps", 64'(hdr_cnt - h0), 64'(1));
      check_val("t5_hdr", 64'(last_hdr), 64'(tc));

      // Randomized ready and start timing.
      for (int k = 0; k < 6; k++) begin
         fill_rand(); rdy_mode = 1;
         repeat ($urandom_range(0, 5)) tick();
         pulse_req();
         wait_idle("rnd");
         check_val("rnd_records", 64'(rec_cnt), 64'(34));
      end
      rdy_mode = 0;

      // Reset while RF record 7 is on offer.
      fill_rand();
      pulse_req();
      n = 0;
      while (!(exp_q.size() != 0 && exp_q[0].tag == 2'd1 && exp_q[0].idx == 8'd7) && n < 100) begin
         tick(); n++;
      end
      check_val("t6_reach_idx7", 64'(n < 100), 64'(1));
      rst = 1'b1; tick();
      check_val("t6_valid", 64'(out_valid), 64'(0));
      check_val("t6_busy", 64'(busy), 64'(0));
      check_val("t6_cycle", 64'(cycle), 64'(0));
      check_val("t6_done", 64'(done), 64'(0));
      rst = 1'b0;
      repeat (4) tick();
      tc = mcyc; h0 = hdr_cnt;
      pulse_req();
      wait_idle("t6");
      check_val("t6_dumps", 64'(hdr_cnt - h0), 64'(1));
      check_val("t6_hdr", 64'(last_hdr), 64'(tc));
      check_val("t6_records", 64'(rec_cnt), 64'(34));

      // Counter wrap: a trigger at 3 fires once per wrap period.
      rst = 1'b1; tick(); rst = 1'b0;
      trig_cycle = 16'd3; trig_en = 1'b1; h0 = hdr_cnt;
      repeat (65536 + 80) tick();
      trig_en = 1'b0;
      check_val("wrap_dumps", 64'(hdr_cnt - h0), 64'(2));
      check_val("wrap_hdr", 64'(last_hdr), 64'(3));
      repeat (2) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
